// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single off-chip memory port between the I-cache and D-cache
//   miss paths. One requester is granted at a time. The memory command stays
//   stable until mem_ready. Read data and a one-cycle ready pulse go back to
//   the granted cache. Grants issued while both caches were waiting are
//   counted for the performance report.
//
//   Build option: define ARB_RR_EN for round-robin arbitration on conflict.
//   When it is undefined, the D-cache always wins a conflict.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   i_read/i_addr                 I-cache line read request (held until i_ready)
//   i_rdata/i_ready               I-cache read data and completion pulse
//   d_read/d_write/d_addr/d_wdata D-cache read / write-back request
//   d_rdata/d_ready               D-cache read data and completion pulse
//   mem_read/mem_write/mem_addr/mem_wdata  registered memory command
//   mem_rdata/mem_ready           memory read data and completion
//   owner                         00 none, 01 I-cache, 10 D-cache
//   conflict_cnt                  saturating count of contended grants
module mem_port_arbiter #(
  parameter int AW = 30,
  parameter int DW = 128,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_read,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ready,
  input  logic          d_read,
  input  logic          d_write,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic [1:0]    owner,
  output logic [CW-1:0] conflict_cnt
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, DONE} state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_I    = 2'b01;
  localparam logic [1:0] OWN_D    = 2'b10;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t          state_q, state_d;
  logic            mem_read_q, mem_read_d;
  logic            mem_write_q, mem_write_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DW-1:0]   i_rdata_q, i_rdata_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;
  logic            i_ready_q, i_ready_d;
  logic            d_ready_q, d_ready_d;
  logic [1:0]      owner_q, owner_d;
  logic [CW-1:0]   conflict_cnt_q, conflict_cnt_d;
`ifdef ARB_RR_EN
  // 1 = D-cache held the last grant, 0 = I-cache.
  logic            last_owner_q, last_owner_d;
`endif

  logic i_req, d_req, contend, pick_d;

  always_comb begin
    state_d        = state_q;
    mem_read_d     = mem_read_q;
    mem_write_d    = mem_write_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    i_rdata_d      = i_rdata_q;
    d_rdata_d      = d_rdata_q;
    i_ready_d      = 1'b0;
    d_ready_d      = 1'b0;
    owner_d        = owner_q;
    conflict_cnt_d = conflict_cnt_q;
`ifdef ARB_RR_EN
    last_owner_d   = last_owner_q;
`endif

    i_req   = i_read;
    d_req   = d_read | d_write;
    contend = i_req & d_req;
`ifdef ARB_RR_EN
    // On a conflict the cache that did not hold the last grant wins.
    pick_d  = d_req & (~i_req | ~last_owner_q);
`else
    pick_d  = d_req;
`endif

    unique case (state_q)
      IDLE: begin
        if (pick_d) begin
          state_d     = GNT_D;
          owner_d     = OWN_D;
          // A write-back takes precedence over a read if both are raised.
          mem_write_d = d_write;
          mem_read_d  = ~d_write;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
        end else if (i_req) begin
          state_d     = GNT_I;
          owner_d     = OWN_I;
          mem_read_d  = 1'b1;
          mem_write_d = 1'b0;
          mem_addr_d  = i_addr;
        end
        if (contend) conflict_cnt_d = sat_inc(conflict_cnt_q);
`ifdef ARB_RR_EN
        if (pick_d)     last_owner_d = 1'b1;
        else if (i_req) last_owner_d = 1'b0;
`endif
      end
      GNT_I: begin
        if (mem_ready) begin
          state_d     = DONE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          i_rdata_d   = mem_rdata;
          i_ready_d   = 1'b1;
        end
      end
      GNT_D: begin
        if (mem_ready) begin
          state_d     = DONE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          // A write-back returns no data, so the last read value is kept.
          if (mem_read_q) d_rdata_d = mem_rdata;
          d_ready_d   = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
      default: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      i_rdata_q      <= '0;
      d_rdata_q      <= '0;
      i_ready_q      <= 1'b0;
      d_ready_q      <= 1'b0;
      owner_q        <= OWN_NONE;
      conflict_cnt_q <= '0;
`ifdef ARB_RR_EN
      last_owner_q   <= 1'b1;
`endif
    end else begin
      state_q        <= state_d;
      mem_read_q     <= mem_read_d;
      mem_write_q    <= mem_write_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      i_rdata_q      <= i_rdata_d;
      d_rdata_q      <= d_rdata_d;
      i_ready_q      <= i_ready_d;
      d_ready_q      <= d_ready_d;
      owner_q        <= owner_d;
      conflict_cnt_q <= conflict_cnt_d;
`ifdef ARB_RR_EN
      last_owner_q   <= last_owner_d;
`endif
    end
  end

  assign mem_read     = mem_read_q;
  assign mem_write    = mem_write_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign i_rdata      = i_rdata_q;
  assign d_rdata      = d_rdata_q;
  assign i_ready      = i_ready_q;
  assign d_ready      = d_ready_q;
  assign owner        = owner_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read;
  logic [29:0]   i_addr;
  logic [127:0]  i_rdata;
  logic          i_ready;
  logic          d_read;
  logic          d_write;
  logic [29:0]   d_addr;
  logic [127:0]  d_wdata;
  logic [127:0]  d_rdata;
  logic          d_ready;
  logic          mem_read;
  logic          mem_write;
  logic [29:0]   mem_addr;
  logic [127:0]  mem_wdata;
  logic [127:0]  mem_rdata;
  logic          mem_ready;
  logic [1:0]    owner;
  logic [15:0]   conflict_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Memory responder settings, written by the main sequence.
  int           mem_lat = 0;
  logic [127:0] rdata_val = '0;

  mem_port_arbiter #(.AW(30), .DW(128), .CW(16)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .owner(owner), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // Memory model: once a command is seen, answer mem_lat cycles later with a
  // single-cycle mem_ready.
  initial begin
    int wait_cnt;
    wait_cnt  = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_ready) begin
        mem_ready = 1'b0;
      end else if (mem_read || mem_write) begin
        if (wait_cnt >= mem_lat) begin
          mem_ready = 1'b1;
          mem_rdata = rdata_val;
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (i_ready || d_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (owner != 2'b00 && (mem_read || mem_write)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    logic         i_read, d_read, d_write;
    logic [29:0]  i_addr, d_addr;
    logic [127:0] d_wdata, rdata;
    int           lat;
    logic [1:0]   exp_owner;
    logic         exp_rd, exp_wr;
    logic [29:0]  exp_addr;
    logic [127:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input int idx, input vec_t v);
    bit ok;
    @(negedge clk);
    i_read = v.i_read; d_read = v.d_read; d_write = v.d_write;
    i_addr = v.i_addr; d_addr = v.d_addr; d_wdata = v.d_wdata;
    mem_lat = v.lat; rdata_val = v.rdata;
    // Command must be visible exactly one cycle after the request.
    @(negedge clk);
    check($sformatf("v%0d_owner", idx), owner, v.exp_owner);
    check($sformatf("v%0d_mem_read", idx), mem_read, v.exp_rd);
    check($sformatf("v%0d_mem_write", idx), mem_write, v.exp_wr);
    check($sformatf("v%0d_mem_addr", idx), mem_addr, v.exp_addr);
    if (v.exp_wr) check($sformatf("v%0d_mem_wdata", idx), mem_wdata, v.d_wdata);
    wait_ready(ok);
    check($sformatf("v%0d_ready_seen", idx), ok, 1'b1);
    check($sformatf("v%0d_i_ready", idx), i_ready, v.exp_owner == 2'b01);
    check($sformatf("v%0d_d_ready", idx), d_ready, v.exp_owner == 2'b10);
    check($sformatf("v%0d_done_owner", idx), owner, v.exp_owner);
    check($sformatf("v%0d_cmd_dropped", idx), mem_read | mem_write, 1'b0);
    if (v.exp_owner == 2'b01) check($sformatf("v%0d_i_rdata", idx), i_rdata, v.exp_rdata);
    else                      check($sformatf("v%0d_d_rdata", idx), d_rdata, v.exp_rdata);
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d_pulse_end", idx), i_ready | d_ready, 1'b0);
    check($sformatf("v%0d_idle_owner", idx), owner, 2'b00);
  endtask

  initial begin
    bit         ok, bad;
    logic [1:0] first, second, exp_own;
    logic [127:0] a5;
    a5 = {16{8'hA5}};

    rst = 1'b1; i_read = 0; d_read = 0; d_write = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0;

    // Reset for one cycle, then five idle cycles.
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_owner", owner, 2'b00);
    check("rst_conflict_cnt", conflict_cnt, 16'd0);
    check("rst_mem_read", mem_read, 1'b0);
    check("rst_mem_write", mem_write, 1'b0);
    check("rst_mem_addr", mem_addr, 30'd0);
    check("rst_mem_wdata", mem_wdata, 128'd0);
    check("rst_i_ready", i_ready, 1'b0);
    check("rst_d_ready", d_ready, 1'b0);
    check("rst_i_rdata", i_rdata, 128'd0);
    check("rst_d_rdata", d_rdata, 128'd0);

    // Single-requester transfers:     ir dr dw  i_addr        d_addr        d_wdata           rdata             lat own rd wr exp_addr      exp_rdata
    vecs[0] = '{1'b1, 1'b0, 1'b0, 30'h40,       30'h0,        128'h0,           a5,               3, 2'b01, 1'b1, 1'b0, 30'h40,       a5};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 30'h0,        30'h123,      128'h0,           128'hDEAD_BEEF,   1, 2'b10, 1'b1, 1'b0, 30'h123,      128'hDEAD_BEEF};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 30'h0,        30'h80,       128'h1234,        128'hFFFF,        2, 2'b10, 1'b0, 1'b1, 30'h80,       128'hDEAD_BEEF};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 30'h0,        30'h3FFFFFFF, 128'hCAFE_0001,   128'h9999,        0, 2'b10, 1'b0, 1'b1, 30'h3FFFFFFF, 128'hDEAD_BEEF};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 30'h3FFFFFFF, 30'h0,        128'h0,           {128{1'b1}},      0, 2'b01, 1'b1, 1'b0, 30'h3FFFFFFF, {128{1'b1}}};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 30'h0,        30'h2A,       128'h0,           {32{4'h5}},       5, 2'b10, 1'b1, 1'b0, 30'h2A,       {32{4'h5}}};
    for (int k = 0; k < 6; k++) run_vec(k, vecs[k]);
    check("single_conflict_cnt", conflict_cnt, 16'd0);

    // Simultaneous I read and D write-back. The last grant was D.
`ifdef ARB_RR_EN
    first = 2'b01; second = 2'b10;
`else
    first = 2'b10; second = 2'b01;
`endif
    @(negedge clk);
    i_read = 1'b1; i_addr = 30'h40;
    d_write = 1'b1; d_addr = 30'h80; d_wdata = 128'h1234;
    mem_lat = 2; rdata_val = 128'h77;
    @(negedge clk);
    check("c1_owner", owner, first);
    check("c1_mem_addr", mem_addr, (first == 2'b10) ? 30'h80 : 30'h40);
    check("c1_mem_write", mem_write, first == 2'b10);
    check("c1_conflict_cnt", conflict_cnt, 16'd1);
    wait_ready(ok);
    check("c1_ready_seen", ok, 1'b1);
    check("c1_d_ready", d_ready, first == 2'b10);
    if (first == 2'b10) d_write = 1'b0; else i_read = 1'b0;
    @(negedge clk);
    check("c_gap_owner", owner, 2'b00);
    @(negedge clk);
    check("c2_owner", owner, second);
    check("c2_mem_addr", mem_addr, (second == 2'b10) ? 30'h80 : 30'h40);
    check("c2_mem_write", mem_write, second == 2'b10);
    if (second == 2'b10) check("c2_mem_wdata", mem_wdata, 128'h1234);
    wait_ready(ok);
    check("c2_ready_seen", ok, 1'b1);
    check("c2_d_ready", d_ready, second == 2'b10);
    check("c_i_rdata", i_rdata, 128'h77);
    check("c_d_rdata", d_rdata, {32{4'h5}});
    check("c2_conflict_cnt", conflict_cnt, 16'd1);
    i_read = 1'b0; d_write = 1'b0;
    @(negedge clk);

    // Reset while a D write-back waits for memory.
    @(negedge clk);
    d_write = 1'b1; d_addr = 30'h55; d_wdata = 128'hABCD; mem_lat = 10;
    @(negedge clk);
    check("r_owner_before", owner, 2'b10);
    check("r_mem_write_before", mem_write, 1'b1);
    @(negedge clk);
    rst = 1'b1; d_write = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("r_mem_write", mem_write, 1'b0);
    check("r_owner", owner, 2'b00);
    check("r_conflict_cnt", conflict_cnt, 16'd0);
    check("r_i_rdata", i_rdata, 128'd0);
    check("r_d_rdata", d_rdata, 128'd0);
    bad = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (d_ready || i_ready || mem_read || mem_write) bad = 1'b1;
    end
    check("r_no_activity", bad, 1'b0);

    // Both caches request continuously for twenty transfers.
    i_read = 1'b1; i_addr = 30'h100; d_read = 1'b1; d_addr = 30'h200; mem_lat = 1;
    for (int k = 0; k < 20; k++) begin
      rdata_val = 128'(k + 1);
`ifdef ARB_RR_EN
      exp_own = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_own = 2'b10;
`endif
      wait_grant(ok);
      check($sformatf("s%0d_grant_seen", k), ok, 1'b1);
      check($sformatf("s%0d_owner", k), owner, exp_own);
      wait_ready(ok);
      check($sformatf("s%0d_ready_seen", k), ok, 1'b1);
    end
    i_read = 1'b0; d_read = 1'b0;
    repeat (3) @(negedge clk);
    check("s_conflict_cnt", conflict_cnt, 16'd20);
    check("s_d_rdata", d_rdata, 128'd20);
    check("s_owner_idle", owner, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
